execute_unit: RTL and testbench

Integer execute stage sitting directly upstream of the 32×32 register file. It accepts two operands (as read from the register file), a 3-bit function code and a destination index. It produces the register file's write port signals (write_address, write_enable, data_in). Single-cycle ALU ops complete in one cycle; multiply runs as a 32-iteration shift-add sequence. A busy/done handshake lets the controller stall fetch until writeback occurs.

---
 rtl/execute_unit.sv | 108 ++++++++++
 tb/tb_execute_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/execute_unit.sv
// Integer execute stage feeding the register-file write port.
// Single-cycle ALU ops plus a 32-iteration shift-add multiplier behind a busy/done handshake.
module execute_unit #(
  parameter int WIDTH         = 32,
  parameter int NUM_LIVE_REGS = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct,
  input  logic [4:0]       dest,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             write_enable,
  output logic [4:0]       write_address,
  output logic [WIDTH-1:0] data_in
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] F_MUL = 3'd6;

  typedef enum logic [1:0] {IDLE, MUL, WB} state_t;

  state_t state, next;

  logic [WIDTH-1:0] acc, mcand, mplier, alu_res, mul_step;
  logic [CW-1:0]    cnt;
  logic [4:0]       dest_q;
  logic             last;

  always_comb begin
    alu_res = '0;
    case (funct)
      3'd0: alu_res = src_a + src_b;
      3'd1: alu_res = src_a - src_b;
      3'd2: alu_res = src_a & src_b;
      3'd3: alu_res = src_a | src_b;
      3'd4: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      3'd5: alu_res = src_a << src_b[4:0];
      3'd7: alu_res = src_a >> src_b[4:0];
      default: alu_res = '0;
    endcase
  end

  assign mul_step = acc + (mplier[0] ? mcand : '0);
  assign last     = (cnt == CW'(WIDTH-1));

  always_comb begin
    next = state;
    case (state)
      IDLE: if (start) next = (funct == F_MUL) ? MUL : WB;
      MUL:  if (last) next = WB;
      WB:   next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // Result and address are loaded on entry to WB so they hold between writebacks.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc           <= '0;
      mcand         <= '0;
      mplier        <= '0;
      cnt           <= '0;
      dest_q        <= '0;
      data_in       <= '0;
      write_address <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (funct == F_MUL) begin
            acc    <= '0;
            mcand  <= src_a;
            mplier <= src_b;
            cnt    <= '0;
            dest_q <= dest;
          end else begin
            data_in       <= alu_res;
            write_address <= dest;
          end
        end
        MUL: begin
          acc    <= mul_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            data_in       <= mul_step;
            write_address <= dest_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign done         = (state == WB);
  assign write_enable = (state == WB) && (32'(write_address) < 32'(NUM_LIVE_REGS));

endmodule

// File: tb/tb_execute_unit.sv
// Directed self-checking bench for execute_unit: ALU ops, multiply latency,
// suppressed destinations, start-while-busy and reset behaviour.
module tb_execute_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct = '0;
  logic [4:0]  dest = '0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        busy, done, write_enable;
  logic [4:0]  write_address;
  logic [31:0] data_in;

  int total = 0;
  int fails = 0;

  execute_unit #(.WIDTH(32), .NUM_LIVE_REGS(24)) dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct), .dest(dest),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .write_enable(write_enable), .write_address(write_address), .data_in(data_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge; returns 1ns into the cycle after accept.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d);
    @(negedge clk);
    funct = f; src_a = a; src_b = b; dest = d; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic alu_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d,
                        input logic [31:0] exp, input logic exp_we);
    issue(f, a, b, d);
    chk({tag, "_data"}, data_in, exp);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_we"}, 32'(write_enable), 32'(exp_we));
    chk({tag, "_addr"}, 32'(write_address), 32'(d));
    step();
    chk({tag, "_idle"}, {29'd0, busy, done, write_enable}, 32'd0);
  endtask

  task automatic mul_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic [31:0] exp);
    int k;
    issue(3'd6, a, b, d);
    k = 1;
    while (!done && k < 40) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      step();
      k++;
    end
    chk({tag, "_lat"}, 32'(k), 32'd33);
    chk({tag, "_data"}, data_in, exp);
    chk({tag, "_we"}, 32'(write_enable), 32'd1);
    chk({tag, "_addr"}, 32'(write_address), 32'(d));
    step();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int wes;
    logic [31:0] wdata;
    logic [4:0]  waddr;

    step(); step();
    chk("rst_out", {busy, done, write_enable, write_address, data_in[25:0]}, 32'd0);
    chk("rst_data", data_in, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    alu_op("add",    3'd0, 32'd10, 32'd2, 5'd5, 32'd12, 1'b1);
    chk("hold_data", data_in, 32'd12);
    chk("hold_addr", 32'(write_address), 32'd5);
    alu_op("sub",    3'd1, 32'd2, 32'd10, 5'd6, 32'hFFFF_FFF8, 1'b1);
    alu_op("slt_t",  3'd4, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'd1, 1'b1);
    alu_op("slt_f",  3'd4, 32'd1, 32'hFFFF_FFFF, 5'd7, 32'd0, 1'b1);
    alu_op("and",    3'd2, 32'h0000_F0F0, 32'h0000_FF00, 5'd1, 32'h0000_F000, 1'b1);
    alu_op("or",     3'd3, 32'h0000_F0F0, 32'h0000_FF00, 5'd1, 32'h0000_FFF0, 1'b1);
    alu_op("sll31",  3'd5, 32'd1, 32'd31, 5'd2, 32'h8000_0000, 1'b1);
    alu_op("sll0",   3'd5, 32'h0000_1234, 32'd32, 5'd2, 32'h0000_1234, 1'b1);
    alu_op("srl31",  3'd7, 32'h8000_0000, 32'd31, 5'd2, 32'd1, 1'b1);
    alu_op("sup25",  3'd0, 32'd3, 32'd4, 5'd25, 32'd7, 1'b0);
    alu_op("live23", 3'd0, 32'd3, 32'd4, 5'd23, 32'd7, 1'b1);
    alu_op("sup24",  3'd0, 32'd5, 32'd4, 5'd24, 32'd9, 1'b0);

    mul_op("mul",    32'd10, 32'd2, 5'd16, 32'd20);
    mul_op("mulwrp", 32'h0001_0000, 32'h0001_0000, 5'd17, 32'd0);
    mul_op("mulneg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 32'd1);

    // A second request and operand changes during a multiply must be ignored.
    issue(3'd6, 32'd7, 32'd6, 5'd9);
    chk("mid_addr_hold", 32'(write_address), 32'd18);
    step(); step(); step();
    @(negedge clk);
    funct = 3'd0; src_a = 32'd100; src_b = 32'd200; dest = 5'd2; start = 1'b1;
    step();
    start = 1'b0;
    wes = 0; wdata = '0; waddr = '0;
    for (int i = 0; i < 40; i++) begin
      if (write_enable) begin
        wes++; wdata = data_in; waddr = write_address;
      end
      step();
    end
    chk("busy_we_cnt", 32'(wes), 32'd1);
    chk("busy_data", wdata, 32'd42);
    chk("busy_addr", 32'(waddr), 32'd9);

    // Reset partway through a multiply discards the pending write.
    issue(3'd6, 32'd5, 32'd5, 5'd4);
    for (int i = 0; i < 9; i++) step();
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("rmul_ctl", {29'd0, busy, done, write_enable}, 32'd0);
    chk("rmul_data", data_in, 32'd0);
    chk("rmul_addr", 32'(write_address), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wes = 0;
    for (int i = 0; i < 40; i++) begin
      if (write_enable) wes++;
      step();
    end
    chk("rmul_nowe", 32'(wes), 32'd0);
    alu_op("post_rst", 3'd0, 32'd1, 32'd1, 5'd3, 32'd2, 1'b1);

    // Reset and start together: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; funct = 3'd0; src_a = 32'd8; src_b = 32'd8; dest = 5'd8;
    step();
    chk("rst_start", {29'd0, busy, done, write_enable}, 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    step();
    chk("rst_start2", {29'd0, busy, done, write_enable}, 32'd0);
    chk("rst_start_d", data_in, 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
